// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: memory-port types shared by the arbiter slice.
// Tag entries record which load requester owns an in-flight tag.
package mem_port_arbiter_pkg;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [31:0] ADDR;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    REQ_Q = 2'd0,
    REQ_R = 2'd1,
    REQ_O = 2'd2
  } REQ_ID;

  typedef struct packed {
    logic  valid;
    REQ_ID owner;
  } tag_entry_t;

  localparam int NUM_TAGS = 2 ** $bits(MEM_TAG);

  function automatic logic [1:0] resp_onehot(REQ_ID owner);
    logic [1:0] oh;
    oh = 2'b00;
    unique case (owner)
      REQ_Q:   oh = 2'b01;
      REQ_R:   oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side bundle of the port arbiter.
// slave = arbiter side, master = requesters/memory model side.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ         = 3,
  parameter int MAX_OUTSTANDING = 8
);
  import mem_port_arbiter_pkg::*;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0]    req_valid;
  ADDR  [NUM_REQ-1:0]    req_addr;
  MEM_BLOCK              req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [1:0]            resp_valid;
  MEM_BLOCK              resp_data;
  MEM_TAG                mem2proc_transaction_tag;
  MEM_BLOCK              mem2proc_data;
  MEM_TAG                mem2proc_data_tag;
  MEM_COMMAND            proc2mem_command;
  ADDR                   proc2mem_addr;
  MEM_BLOCK              proc2mem_data;
  logic [CW-1:0]         outstanding;
  logic                  tag_error;

  modport slave (
    input  req_valid, req_addr, req_data,
    input  mem2proc_transaction_tag, mem2proc_data,
    input  mem2proc_data_tag,
    output req_ready, resp_valid, resp_data,
    output proc2mem_command, proc2mem_addr,
    output proc2mem_data, outstanding, tag_error
  );

  modport master (
    output req_valid, req_addr, req_data,
    output mem2proc_transaction_tag, mem2proc_data,
    output mem2proc_data_tag,
    input  req_ready, resp_valid, resp_data,
    input  proc2mem_command, proc2mem_addr,
    input  proc2mem_data, outstanding, tag_error
  );

endinterface

// File: rtl/mem_port_arbiter_tag_table.sv
// mem_tag_table: owner table for in-flight load tags.
// A free and an alloc of the same tag in one cycle leave the entry allocated.
module mem_tag_table
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_en,
  input  MEM_TAG     alloc_tag,
  input  REQ_ID      alloc_owner,
  input  logic       free_en,
  input  MEM_TAG     free_tag,
  output tag_entry_t lookup_entry
);

  logic [NUM_TAGS-1:0] valid_q;
  REQ_ID               owner_q [NUM_TAGS];

  assign lookup_entry = '{
    valid: valid_q[free_tag],
    owner: owner_q[free_tag]
  };

  // Alloc is written after free so it wins on a shared tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (free_en)
        valid_q[free_tag] <= 1'b0;
      if (alloc_en)
        valid_q[alloc_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en)
      owner_q[alloc_tag] <= alloc_owner;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between Q/R loads and O stores.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed O > Q > R.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] ready;
  logic               has_win;
  REQ_ID              win;
  logic               accept;
  logic               alloc;
  logic               free;
  logic               bad;
  tag_entry_t         entry;
  logic [1:0]         resp_valid_q;
  MEM_BLOCK           resp_data_q;
  logic               tag_error_q;

  // Loads stall at the outstanding limit; stores are never tracked.
  always_comb begin
    elig = bus.req_valid;
    if (cnt_q >= MAX_CNT) begin
      elig[REQ_Q] = 1'b0;
      elig[REQ_R] = 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_q;
  logic [2:0] sum;

  always_comb begin
    has_win = 1'b0;
    win     = REQ_Q;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      if (sum >= 3'(NUM_REQ))
        sum = sum - 3'(NUM_REQ);
      if (!has_win && elig[sum[1:0]]) begin
        has_win = 1'b1;
        win     = REQ_ID'(sum[1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= 2'd0;
    else if (accept)
      rr_q <= (win == REQ_O) ? 2'd0 : 2'(win) + 2'd1;
  end
`else
  always_comb begin
    has_win = 1'b1;
    win     = REQ_O;
    if (elig[REQ_O])
      win = REQ_O;
    else if (elig[REQ_Q])
      win = REQ_Q;
    else if (elig[REQ_R])
      win = REQ_R;
    else
      has_win = 1'b0;
  end
`endif

  always_comb begin
    bus.proc2mem_command = MEM_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (has_win) begin
      bus.proc2mem_addr = bus.req_addr[win];
      if (win == REQ_O) begin
        bus.proc2mem_command = MEM_STORE;
        bus.proc2mem_data    = bus.req_data;
      end else begin
        bus.proc2mem_command = MEM_LOAD;
      end
    end
  end

  assign accept = has_win &&
                  (bus.mem2proc_transaction_tag != '0);
  assign alloc  = accept && (win != REQ_O);

  always_comb begin
    ready = '0;
    if (accept)
      ready[win] = 1'b1;
  end

  assign bus.req_ready = ready;

  mem_tag_table u_tags (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc),
    .alloc_tag    (bus.mem2proc_transaction_tag),
    .alloc_owner  (win),
    .free_en      (free),
    .free_tag     (bus.mem2proc_data_tag),
    .lookup_entry (entry)
  );

  assign free = (bus.mem2proc_data_tag != '0) && entry.valid;
  assign bad  = (bus.mem2proc_data_tag != '0) && !entry.valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      unique case ({alloc, free})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      tag_error_q  <= 1'b0;
    end else begin
      resp_valid_q <= free ? resp_onehot(entry.owner) : 2'b00;
      if (free)
        resp_data_q <= bus.mem2proc_data;
      if (bad)
        tag_error_q <= 1'b1;
    end
  end

  assign bus.outstanding = cnt_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.tag_error   = tag_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a queued response scoreboard.
// Grant order checks follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXO = 2;

  typedef struct packed {
    logic [1:0] rv;
    MEM_BLOCK   d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e;
  logic [100:0] w;
  logic [100:0] cmd_view;
  logic [65:0]  resp_view;

  localparam MEM_BLOCK ODATA = 64'hDEAD_BEEF_0000_0002;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(3), .MAX_OUTSTANDING(MAXO)) bus ();

  mem_port_arbiter #(.NUM_REQ(3), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign cmd_view  = {bus.req_ready, bus.proc2mem_command,
                      bus.proc2mem_addr, bus.proc2mem_data};
  assign resp_view = {bus.resp_valid, bus.resp_data};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid                = '0;
    bus.mem2proc_transaction_tag = '0;
    bus.mem2proc_data_tag        = '0;
    bus.mem2proc_data            = '0;
  endtask

  task automatic apply_reset();
    idle();
    bus.req_addr[0] = 32'h100;
    bus.req_addr[1] = 32'h200;
    bus.req_addr[2] = 32'h300;
    bus.req_data    = ODATA;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    #2;
    n_cmp++;
    if ({bus.outstanding, bus.resp_valid, bus.tag_error} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 0",
               {bus.outstanding, bus.resp_valid, bus.tag_error});
    end
    n_cmp++;
    if (bus.resp_data !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", bus.resp_data);
    end
    w = {3'b000, MEM_NONE, 32'h0, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL reset_cmd: got %h want %h", cmd_view, w);
    end
  endtask

  task automatic test_single_load();
    apply_reset();
    bus.req_valid = 3'b001;
    bus.mem2proc_transaction_tag = 4'd3;
    #2;
    w = {3'b001, MEM_LOAD, 32'h100, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL q_load_cmd: got %h want %h", cmd_view, w);
    end
    tick();
    idle();
    n_cmp++;
    if (bus.outstanding !== 2'd1) begin
      n_bad++;
      $display("FAIL q_load_out: got %0d want 1", bus.outstanding);
    end
    bus.mem2proc_data_tag = 4'd3;
    bus.mem2proc_data     = 64'h1111_2222_3333_4444;
    sb.push_back({2'b01, 64'h1111_2222_3333_4444});
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL q_load_resp: got %h want %h", resp_view, e);
    end
    n_cmp++;
    if (bus.outstanding !== 2'd0) begin
      n_bad++;
      $display("FAIL q_load_out0: got %0d want 0", bus.outstanding);
    end
    tick();
    n_cmp++;
    if (bus.resp_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL q_resp_pulse: got %b want 00", bus.resp_valid);
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    bus.req_valid = 3'b111;
    bus.mem2proc_transaction_tag = 4'd1;
    #2;
    w = {3'b001, MEM_LOAD, 32'h100, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL rr_g0: got %h want %h", cmd_view, w);
    end
    tick();
    bus.mem2proc_transaction_tag = 4'd2;
    #2;
    w = {3'b010, MEM_LOAD, 32'h200, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL rr_g1: got %h want %h", cmd_view, w);
    end
    tick();
    bus.mem2proc_transaction_tag = 4'd3;
    bus.mem2proc_data_tag = 4'd1;
    bus.mem2proc_data = 64'hA1;
    sb.push_back({2'b01, 64'hA1});
    #2;
    w = {3'b100, MEM_STORE, 32'h300, ODATA};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL rr_g2: got %h want %h", cmd_view, w);
    end
    tick();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL rr_resp_q: got %h want %h", resp_view, e);
    end
    bus.mem2proc_transaction_tag = 4'd4;
    bus.mem2proc_data_tag = 4'd2;
    bus.mem2proc_data = 64'hB2;
    sb.push_back({2'b10, 64'hB2});
    #2;
    w = {3'b001, MEM_LOAD, 32'h100, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL rr_g3: got %h want %h", cmd_view, w);
    end
    tick();
    idle();
    bus.mem2proc_data_tag = 4'd4;
    bus.mem2proc_data = 64'hC3;
`else
    bus.req_valid = 3'b111;
    bus.mem2proc_transaction_tag = 4'd1;
    #2;
    w = {3'b100, MEM_STORE, 32'h300, ODATA};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL fp_o_first: got %h want %h", cmd_view, w);
    end
    tick();
    bus.req_valid = 3'b011;
    bus.mem2proc_transaction_tag = 4'd2;
    #2;
    w = {3'b001, MEM_LOAD, 32'h100, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL fp_q_next: got %h want %h", cmd_view, w);
    end
    tick();
    bus.mem2proc_transaction_tag = 4'd3;
    #2;
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL fp_q_held: got %h want %h", cmd_view, w);
    end
    tick();
    bus.req_valid = 3'b010;
    bus.mem2proc_transaction_tag = 4'd4;
    bus.mem2proc_data_tag = 4'd2;
    bus.mem2proc_data = 64'hB2;
    sb.push_back({2'b01, 64'hB2});
    #2;
    w = {3'b000, MEM_NONE, 32'h0, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL fp_r_blocked: got %h want %h", cmd_view, w);
    end
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL fp_resp_q2: got %h want %h", resp_view, e);
    end
    bus.mem2proc_data_tag = 4'd3;
    bus.mem2proc_data = 64'hC3;
`endif
    sb.push_back({2'b01, 64'hC3});
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL arb_resp_a: got %h want %h", resp_view, e);
    end
`ifdef ARB_ROUND_ROBIN_EN
    // R's tag-2 response was pushed ahead of the final Q one
    tick();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL arb_resp_b: got %h want %h", resp_view, e);
    end
`endif
    n_cmp++;
    if (bus.outstanding !== 2'd0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL arb_drain: got %0d/%0d want 0/0",
               bus.outstanding, sb.size());
    end
  endtask

  task automatic test_max_outstanding();
    apply_reset();
    bus.req_valid = 3'b001;
    bus.mem2proc_transaction_tag = 4'd5;
    tick();
    bus.req_valid = 3'b010;
    bus.mem2proc_transaction_tag = 4'd6;
    tick();
    n_cmp++;
    if (bus.outstanding !== 2'd2) begin
      n_bad++;
      $display("FAIL max_out2: got %0d want 2", bus.outstanding);
    end
    bus.req_valid = 3'b111;
    bus.mem2proc_transaction_tag = 4'd7;
    #2;
    w = {3'b100, MEM_STORE, 32'h300, ODATA};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL max_store: got %h want %h", cmd_view, w);
    end
    tick();
    bus.req_valid = 3'b011;
    bus.mem2proc_transaction_tag = 4'd8;
    #2;
    w = {3'b000, MEM_NONE, 32'h0, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL max_block: got %h want %h", cmd_view, w);
    end
    tick();
    idle();
    n_cmp++;
    if (bus.outstanding !== 2'd2) begin
      n_bad++;
      $display("FAIL max_hold: got %0d want 2", bus.outstanding);
    end
    bus.mem2proc_data_tag = 4'd5;
    bus.mem2proc_data = 64'h55;
    sb.push_back({2'b01, 64'h55});
    tick();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL max_resp_q: got %h want %h", resp_view, e);
    end
    bus.mem2proc_data_tag = 4'd6;
    bus.mem2proc_data = 64'h66;
    sb.push_back({2'b10, 64'h66});
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL max_resp_r: got %h want %h", resp_view, e);
    end
    n_cmp++;
    if (bus.outstanding !== 2'd0) begin
      n_bad++;
      $display("FAIL max_drain: got %0d want 0", bus.outstanding);
    end
  endtask

  task automatic test_refused();
    apply_reset();
    bus.req_valid = 3'b001;
    bus.req_addr[0] = 32'h240;
    for (int i = 0; i < 3; i++) begin
      #2;
      w = {3'b000, MEM_LOAD, 32'h240, 64'h0};
      n_cmp++;
      if (cmd_view !== w || bus.outstanding !== 2'd0) begin
        n_bad++;
        $display("FAIL refused_%0d: got %h/%0d want %h/0",
                 i, cmd_view, bus.outstanding, w);
      end
      tick();
    end
    bus.mem2proc_transaction_tag = 4'd9;
    #2;
    w = {3'b001, MEM_LOAD, 32'h240, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL refused_accept: got %h want %h", cmd_view, w);
    end
    tick();
    idle();
    bus.req_addr[0] = 32'h100;
    bus.mem2proc_data_tag = 4'd9;
    bus.mem2proc_data = 64'h99;
    sb.push_back({2'b01, 64'h99});
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL refused_resp: got %h want %h", resp_view, e);
    end
  endtask

  task automatic test_tag_error();
    apply_reset();
    bus.mem2proc_data_tag = 4'd7;
    bus.mem2proc_data = 64'h77;
    tick();
    idle();
    n_cmp++;
    if ({bus.resp_valid, bus.tag_error, bus.outstanding} !== 5'b00100) begin
      n_bad++;
      $display("FAIL tag7_err: got %b want 00100",
               {bus.resp_valid, bus.tag_error, bus.outstanding});
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.tag_error !== 1'b1) begin
      n_bad++;
      $display("FAIL tag_err_sticky: got %b want 1", bus.tag_error);
    end
    bus.req_valid = 3'b001;
    bus.mem2proc_transaction_tag = 4'd10;
    tick();
    apply_reset();
    n_cmp++;
    if ({bus.tag_error, bus.outstanding} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_clears: got %b want 000",
               {bus.tag_error, bus.outstanding});
    end
    bus.mem2proc_data_tag = 4'd10;
    bus.mem2proc_data = 64'hAA;
    tick();
    idle();
    n_cmp++;
    if ({bus.resp_valid, bus.tag_error, bus.outstanding} !== 5'b00100) begin
      n_bad++;
      $display("FAIL late_data: got %b want 00100",
               {bus.resp_valid, bus.tag_error, bus.outstanding});
    end
  endtask

  task automatic test_same_tag();
    apply_reset();
    bus.req_valid = 3'b010;
    bus.mem2proc_transaction_tag = 4'd5;
    tick();
    bus.req_valid = 3'b001;
    bus.mem2proc_transaction_tag = 4'd5;
    bus.mem2proc_data_tag = 4'd5;
    bus.mem2proc_data = 64'h5A5A;
    sb.push_back({2'b10, 64'h5A5A});
    #2;
    w = {3'b001, MEM_LOAD, 32'h100, 64'h0};
    n_cmp++;
    if (cmd_view !== w) begin
      n_bad++;
      $display("FAIL same_accept: got %h want %h", cmd_view, w);
    end
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL same_resp_r: got %h want %h", resp_view, e);
    end
    n_cmp++;
    if (bus.outstanding !== 2'd1) begin
      n_bad++;
      $display("FAIL same_out: got %0d want 1", bus.outstanding);
    end
    bus.mem2proc_data_tag = 4'd5;
    bus.mem2proc_data = 64'hA5A5;
    sb.push_back({2'b01, 64'hA5A5});
    tick();
    idle();
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_cmp++;
    if (resp_view !== e) begin
      n_bad++;
      $display("FAIL same_owner_q: got %h want %h", resp_view, e);
    end
    n_cmp++;
    if (bus.outstanding !== 2'd0) begin
      n_bad++;
      $display("FAIL same_out0: got %0d want 0", bus.outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_arbitration();
    test_max_outstanding();
    test_refused();
    test_tag_error();
    test_same_tag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
